// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the decoded-control payload.
// Contents: opcode/funct encodings, ALU op codes, branch type codes,
// immediate/destination select enums and the ctrl_t decode record.
package mips_pkg;

  localparam int unsigned OPC_W    = 6;
  localparam int unsigned FN_W     = 6;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned BR_W     = 2;
  localparam int unsigned IMM_W    = 16;

  // Primary opcodes
  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [FN_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FN_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FN_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FN_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FN_W-1:0] FN_AND  = 6'h24;
  localparam logic [FN_W-1:0] FN_OR   = 6'h25;
  localparam logic [FN_W-1:0] FN_XOR  = 6'h26;
  localparam logic [FN_W-1:0] FN_NOR  = 6'h27;
  localparam logic [FN_W-1:0] FN_SLT  = 6'h2A;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b1010;

  // Branch type codes
  localparam logic [BR_W-1:0] BR_NONE = 2'b00;
  localparam logic [BR_W-1:0] BR_EQ   = 2'b01;
  localparam logic [BR_W-1:0] BR_NE   = 2'b10;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SIGN = 2'd1,
    IMM_ZERO = 2'd2
  } imm_sel_e;

  typedef enum logic {
    DST_RT = 1'b0,
    DST_RD = 1'b1
  } dst_sel_e;

  // Decoded control for one instruction
  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    imm_sel_e            imm_sel;
    dst_sel_e            dst_sel;
    logic                wr_en;
    logic                rt_used;
    logic                is_load;
    logic                is_store;
    logic [BR_W-1:0]     branch;
    logic                illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl.sv
// Combinational opcode/funct decoder feeding the issue stage.
// Ports: i_opcode, i_funct (instruction fields) -> o_ctrl_c (decoded ctrl_t).
module alu_ctrl
  import mips_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [FN_W-1:0]  i_funct,
  output ctrl_t            o_ctrl_c
);

  // Decode table; unknown encodings flag illegal with no side effects.
  always_comb begin
    o_ctrl_c.alu_op   = ALU_ADD;
    o_ctrl_c.imm_sel  = IMM_NONE;
    o_ctrl_c.dst_sel  = DST_RT;
    o_ctrl_c.wr_en    = 1'b0;
    o_ctrl_c.rt_used  = 1'b0;
    o_ctrl_c.is_load  = 1'b0;
    o_ctrl_c.is_store = 1'b0;
    o_ctrl_c.branch   = BR_NONE;
    o_ctrl_c.illegal  = 1'b0;

    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl_c.dst_sel = DST_RD;
        o_ctrl_c.wr_en   = 1'b1;
        o_ctrl_c.rt_used = 1'b1;
        case (i_funct)
          FN_ADD, FN_ADDU: o_ctrl_c.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: o_ctrl_c.alu_op = ALU_SUB;
          FN_AND:          o_ctrl_c.alu_op = ALU_AND;
          FN_OR:           o_ctrl_c.alu_op = ALU_OR;
          FN_XOR:          o_ctrl_c.alu_op = ALU_XOR;
          FN_NOR:          o_ctrl_c.alu_op = ALU_NOR;
          FN_SLT:          o_ctrl_c.alu_op = ALU_SLT;
          default: begin
            o_ctrl_c.illegal = 1'b1;
            o_ctrl_c.wr_en   = 1'b0;
            o_ctrl_c.rt_used = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        o_ctrl_c.imm_sel = IMM_SIGN;
        o_ctrl_c.wr_en   = 1'b1;
      end
      OP_SLTI: begin
        o_ctrl_c.alu_op  = ALU_SLT;
        o_ctrl_c.imm_sel = IMM_SIGN;
        o_ctrl_c.wr_en   = 1'b1;
      end
      OP_ANDI: begin
        o_ctrl_c.alu_op  = ALU_AND;
        o_ctrl_c.imm_sel = IMM_ZERO;
        o_ctrl_c.wr_en   = 1'b1;
      end
      OP_ORI: begin
        o_ctrl_c.alu_op  = ALU_OR;
        o_ctrl_c.imm_sel = IMM_ZERO;
        o_ctrl_c.wr_en   = 1'b1;
      end
      OP_XORI: begin
        o_ctrl_c.alu_op  = ALU_XOR;
        o_ctrl_c.imm_sel = IMM_ZERO;
        o_ctrl_c.wr_en   = 1'b1;
      end
      OP_LW: begin
        o_ctrl_c.imm_sel = IMM_SIGN;
        o_ctrl_c.wr_en   = 1'b1;
        o_ctrl_c.is_load = 1'b1;
      end
      OP_SW: begin
        o_ctrl_c.imm_sel  = IMM_SIGN;
        o_ctrl_c.rt_used  = 1'b1;
        o_ctrl_c.is_store = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl_c.alu_op  = ALU_SUB;
        o_ctrl_c.rt_used = 1'b1;
        o_ctrl_c.branch  = BR_EQ;
      end
      OP_BNE: begin
        o_ctrl_c.alu_op  = ALU_SUB;
        o_ctrl_c.rt_used = 1'b1;
        o_ctrl_c.branch  = BR_NE;
      end
      default: o_ctrl_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX issue stage in front of the 32-bit ALU: decode, operand-B select,
// EX/MEM forwarding, load-use hazard detection and the ID/EX registers.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          decode-side handshake (in_ready combinational)
//   in_opcode..in_imm16        instruction fields and register-file data
//   flush, ex_stall            pipeline control
//   ex_result                  result of the instruction held here
//   mem_wr_en/idx/data         MEM/WB writeback for forwarding
//   out_valid..out_illegal     registered EX-stage operands and control
module ex_issue_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPC_W-1:0]     in_opcode,
  input  logic [FN_W-1:0]      in_funct,
  input  logic [REG_IDX_W-1:0] in_rs_idx,
  input  logic [REG_IDX_W-1:0] in_rt_idx,
  input  logic [REG_IDX_W-1:0] in_rd_idx,
  input  logic [DATA_W-1:0]    in_rs_val,
  input  logic [DATA_W-1:0]    in_rt_val,
  input  logic [IMM_W-1:0]     in_imm16,
  input  logic                 flush,
  input  logic                 ex_stall,
  input  logic [DATA_W-1:0]    ex_result,
  input  logic                 mem_wr_en,
  input  logic [REG_IDX_W-1:0] mem_wr_idx,
  input  logic [DATA_W-1:0]    mem_wr_data,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 out_wr_en,
  output logic [REG_IDX_W-1:0] out_wr_idx,
  output logic                 out_is_load,
  output logic                 out_is_store,
  output logic [DATA_W-1:0]    out_store_data,
  output logic [BR_W-1:0]      out_branch,
  output logic                 out_illegal
);

  localparam int unsigned EXT_W = DATA_W - IMM_W;

  ctrl_t                w_ctrl;
  logic                 w_ex_fwd_ok;
  logic [DATA_W-1:0]    w_rs_fwd;
  logic [DATA_W-1:0]    w_rt_fwd;
  logic [DATA_W-1:0]    w_alu_b;
  logic [REG_IDX_W-1:0] w_dst_idx;
  logic                 w_wr_en;
  logic                 w_hazard;
  logic                 w_accept;

  logic                 r_valid;
  logic [DATA_W-1:0]    r_alu_a;
  logic [DATA_W-1:0]    r_alu_b;
  logic [ALU_OP_W-1:0]  r_alu_op;
  logic                 r_wr_en;
  logic [REG_IDX_W-1:0] r_wr_idx;
  logic                 r_is_load;
  logic                 r_is_store;
  logic [DATA_W-1:0]    r_store_data;
  logic [BR_W-1:0]      r_branch;
  logic                 r_illegal;

  alu_ctrl u_alu_ctrl (
    .i_opcode (in_opcode),
    .i_funct  (in_funct),
    .o_ctrl_c (w_ctrl)
  );

  // A held load has no result yet, so it must never feed the EX path.
  assign w_ex_fwd_ok = r_valid & r_wr_en & ~r_is_load;

  // Source operand forwarding: r0, then EX, then MEM, then register file.
  always_comb begin
    w_rs_fwd = in_rs_val;
    if (in_rs_idx == '0)
      w_rs_fwd = '0;
    else if (w_ex_fwd_ok && (in_rs_idx == r_wr_idx))
      w_rs_fwd = ex_result;
    else if (mem_wr_en && (in_rs_idx == mem_wr_idx))
      w_rs_fwd = mem_wr_data;
  end

  always_comb begin
    w_rt_fwd = in_rt_val;
    if (in_rt_idx == '0)
      w_rt_fwd = '0;
    else if (w_ex_fwd_ok && (in_rt_idx == r_wr_idx))
      w_rt_fwd = ex_result;
    else if (mem_wr_en && (in_rt_idx == mem_wr_idx))
      w_rt_fwd = mem_wr_data;
  end

  // Operand B: forwarded rt or the extended immediate.
  always_comb begin
    w_alu_b = w_rt_fwd;
    case (w_ctrl.imm_sel)
      IMM_SIGN: w_alu_b = {{EXT_W{in_imm16[IMM_W-1]}}, in_imm16};
      IMM_ZERO: w_alu_b = {{EXT_W{1'b0}}, in_imm16};
      default:  w_alu_b = w_rt_fwd;
    endcase
  end

  assign w_dst_idx = (w_ctrl.dst_sel == DST_RD) ? in_rd_idx : in_rt_idx;
  assign w_wr_en   = w_ctrl.wr_en & (w_dst_idx != '0);

  // Load-use: consumer of a held load waits one cycle for the MEM path.
  assign w_hazard = in_valid & r_valid & r_is_load & r_wr_en &
                    ((in_rs_idx == r_wr_idx) |
                     (w_ctrl.rt_used & (in_rt_idx == r_wr_idx)));

  assign in_ready = ~ex_stall & ~w_hazard & ~flush;
  assign w_accept = in_valid & in_ready;

  // ID/EX register: flush > stall > accept > bubble (datapath holds).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_wr_en      <= 1'b0;
      r_wr_idx     <= '0;
      r_is_load    <= 1'b0;
      r_is_store   <= 1'b0;
      r_store_data <= '0;
      r_branch     <= '0;
      r_illegal    <= 1'b0;
    end else if (flush || (!ex_stall && !w_accept)) begin
      r_valid    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_branch   <= '0;
      r_illegal  <= 1'b0;
    end else if (!ex_stall) begin
      r_valid      <= 1'b1;
      r_alu_a      <= w_rs_fwd;
      r_alu_b      <= w_alu_b;
      r_alu_op     <= w_ctrl.alu_op;
      r_wr_en      <= w_wr_en;
      r_wr_idx     <= w_dst_idx;
      r_is_load    <= w_ctrl.is_load;
      r_is_store   <= w_ctrl.is_store;
      r_store_data <= w_rt_fwd;
      r_branch     <= w_ctrl.branch;
      r_illegal    <= w_ctrl.illegal;
    end
  end

  assign out_valid      = r_valid;
  assign alu_a          = r_alu_a;
  assign alu_b          = r_alu_b;
  assign alu_op         = r_alu_op;
  assign out_wr_en      = r_wr_en;
  assign out_wr_idx     = r_wr_idx;
  assign out_is_load    = r_is_load;
  assign out_is_store   = r_is_store;
  assign out_store_data = r_store_data;
  assign out_branch     = r_branch;
  assign out_illegal    = r_illegal;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Self-checking bench for ex_issue_stage: vector table with a scoreboard
// queue, plus a hand-written asynchronous-reset sequence.
module tb_ex_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_funct;
  logic [4:0]  in_rs_idx;
  logic [4:0]  in_rt_idx;
  logic [4:0]  in_rd_idx;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [15:0] in_imm16;
  logic        flush;
  logic        ex_stall;
  logic [31:0] ex_result;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_idx;
  logic [31:0] mem_wr_data;
  logic        out_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic        out_wr_en;
  logic [4:0]  out_wr_idx;
  logic        out_is_load;
  logic        out_is_store;
  logic [31:0] out_store_data;
  logic [1:0]  out_branch;
  logic        out_illegal;

  ex_issue_stage #(.DATA_W(32), .REG_IDX_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_opcode      (in_opcode),
    .in_funct       (in_funct),
    .in_rs_idx      (in_rs_idx),
    .in_rt_idx      (in_rt_idx),
    .in_rd_idx      (in_rd_idx),
    .in_rs_val      (in_rs_val),
    .in_rt_val      (in_rt_val),
    .in_imm16       (in_imm16),
    .flush          (flush),
    .ex_stall       (ex_stall),
    .ex_result      (ex_result),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_idx     (mem_wr_idx),
    .mem_wr_data    (mem_wr_data),
    .out_valid      (out_valid),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_op         (alu_op),
    .out_wr_en      (out_wr_en),
    .out_wr_idx     (out_wr_idx),
    .out_is_load    (out_is_load),
    .out_is_store   (out_is_store),
    .out_store_data (out_store_data),
    .out_branch     (out_branch),
    .out_illegal    (out_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_v;
    logic [31:0] rt_v;
    logic [15:0] imm;
    logic        fl;
    logic        stall;
    logic [31:0] ex_res;
    logic        mwe;
    logic [4:0]  midx;
    logic [31:0] mdata;
  } stim_t;

  typedef struct packed {
    logic        rdy;
    logic        vld;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        we;
    logic [4:0]  widx;
    logic        ld;
    logic        st;
    logic [1:0]  br;
    logic        ill;
    logic [31:0] sd;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  localparam int NV = 32;

  vec_t tv [NV];
  exp_t sb_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic stim_t mk_s(input logic v, input logic [5:0] op, input logic [5:0] fn,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [31:0] rsv, input logic [31:0] rtv,
                                 input logic [15:0] imm);
    stim_t s;
    s       = '0;
    s.valid = v;
    s.op    = op;
    s.fn    = fn;
    s.rs    = rs;
    s.rt    = rt;
    s.rd    = rd;
    s.rs_v  = rsv;
    s.rt_v  = rtv;
    s.imm   = imm;
    return s;
  endfunction

  function automatic exp_t mk_e(input logic rdy, input logic vld, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] op, input logic we,
                                input logic [4:0] widx, input logic ld, input logic st,
                                input logic [1:0] br, input logic ill, input logic [31:0] sd);
    exp_t e;
    e.rdy  = rdy;
    e.vld  = vld;
    e.a    = a;
    e.b    = b;
    e.op   = op;
    e.we   = we;
    e.widx = widx;
    e.ld   = ld;
    e.st   = st;
    e.br   = br;
    e.ill  = ill;
    e.sd   = sd;
    return e;
  endfunction

  task automatic chk(input string nm, input int vi, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", nm, vi, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    in_valid    = s.valid;
    in_opcode   = s.op;
    in_funct    = s.fn;
    in_rs_idx   = s.rs;
    in_rt_idx   = s.rt;
    in_rd_idx   = s.rd;
    in_rs_val   = s.rs_v;
    in_rt_val   = s.rt_v;
    in_imm16    = s.imm;
    flush       = s.fl;
    ex_stall    = s.stall;
    ex_result   = s.ex_res;
    mem_wr_en   = s.mwe;
    mem_wr_idx  = s.midx;
    mem_wr_data = s.mdata;
  endtask

  task automatic check_outputs(input int vi, input exp_t e);
    chk("out_valid",      vi, 32'(out_valid),    32'(e.vld));
    chk("alu_a",          vi, alu_a,             e.a);
    chk("alu_b",          vi, alu_b,             e.b);
    chk("alu_op",         vi, 32'(alu_op),       32'(e.op));
    chk("out_wr_en",      vi, 32'(out_wr_en),    32'(e.we));
    chk("out_wr_idx",     vi, 32'(out_wr_idx),   32'(e.widx));
    chk("out_is_load",    vi, 32'(out_is_load),  32'(e.ld));
    chk("out_is_store",   vi, 32'(out_is_store), 32'(e.st));
    chk("out_branch",     vi, 32'(out_branch),   32'(e.br));
    chk("out_illegal",    vi, 32'(out_illegal),  32'(e.ill));
    chk("out_store_data", vi, out_store_data,    e.sd);
  endtask

  initial begin : main
    exp_t  e;
    stim_t s;

    // add / andi / slti
    tv[0].s  = mk_s(1, 6'h00, 6'h20, 1, 2, 3, 5, 7, 0);
    tv[0].e  = mk_e(1, 1, 5, 7, 4'b0000, 1, 3, 0, 0, 0, 0, 7);
    tv[1].s  = mk_s(1, 6'h0C, 6'h00, 1, 4, 4, 32'h11, 32'h22, 16'hFFFF);
    tv[1].e  = mk_e(1, 1, 32'h11, 32'h0000FFFF, 4'b0100, 1, 4, 0, 0, 0, 0, 32'h22);
    tv[2].s  = mk_s(1, 6'h0A, 6'h00, 1, 5, 5, 3, 0, 16'hFFFF);
    tv[2].e  = mk_e(1, 1, 3, 32'hFFFFFFFF, 4'b1010, 1, 5, 0, 0, 0, 0, 0);
    // EX forwarding, then EX beating MEM
    tv[3].s  = mk_s(1, 6'h00, 6'h20, 1, 1, 2, 4, 4, 0);
    tv[3].e  = mk_e(1, 1, 4, 4, 4'b0000, 1, 2, 0, 0, 0, 0, 4);
    tv[4].s  = mk_s(1, 6'h00, 6'h22, 2, 2, 5, 32'hDEAD, 32'hDEAD, 0);
    tv[4].s.ex_res = 32'h10;
    tv[4].e  = mk_e(1, 1, 32'h10, 32'h10, 4'b0010, 1, 5, 0, 0, 0, 0, 32'h10);
    tv[5]    = tv[3];
    tv[6]    = tv[4];
    tv[6].s.mwe   = 1;
    tv[6].s.midx  = 2;
    tv[6].s.mdata = 32'h99;
    // MEM forwarding alone
    tv[7].s  = mk_s(1, 6'h00, 6'h25, 9, 10, 8, 32'h1, 32'hF0, 0);
    tv[7].s.mwe   = 1;
    tv[7].s.midx  = 9;
    tv[7].s.mdata = 32'h99;
    tv[7].e  = mk_e(1, 1, 32'h99, 32'hF0, 4'b0101, 1, 8, 0, 0, 0, 0, 32'hF0);
    // load-use: one bubble, then MEM supplies the load data
    tv[8].s  = mk_s(1, 6'h23, 6'h00, 1, 6, 6, 32'h100, 32'h55, 16'h0004);
    tv[8].e  = mk_e(1, 1, 32'h100, 4, 4'b0000, 1, 6, 1, 0, 0, 0, 32'h55);
    tv[9].s  = mk_s(1, 6'h00, 6'h20, 6, 1, 7, 0, 1, 0);
    tv[9].e  = mk_e(0, 0, 32'h100, 4, 4'b0000, 0, 6, 0, 0, 0, 0, 32'h55);
    tv[10]   = tv[9];
    tv[10].s.mwe   = 1;
    tv[10].s.midx  = 6;
    tv[10].s.mdata = 32'hAB;
    tv[10].e = mk_e(1, 1, 32'hAB, 1, 4'b0000, 1, 7, 0, 0, 0, 0, 1);
    // sw with store data forwarded from EX, branches, illegal
    tv[11].s = mk_s(1, 6'h2B, 6'h00, 2, 7, 7, 32'h200, 3, 16'h0008);
    tv[11].s.ex_res = 32'h77;
    tv[11].e = mk_e(1, 1, 32'h200, 8, 4'b0000, 0, 7, 0, 1, 0, 0, 32'h77);
    tv[12].s = mk_s(1, 6'h04, 6'h00, 1, 2, 2, 9, 9, 0);
    tv[12].e = mk_e(1, 1, 9, 9, 4'b0010, 0, 2, 0, 0, 2'b01, 0, 9);
    tv[13].s = mk_s(1, 6'h05, 6'h00, 3, 4, 4, 1, 2, 0);
    tv[13].e = mk_e(1, 1, 1, 2, 4'b0010, 0, 4, 0, 0, 2'b10, 0, 2);
    tv[14].s = mk_s(1, 6'h3F, 6'h00, 1, 2, 2, 5, 0, 0);
    tv[14].e = mk_e(1, 1, 5, 0, 4'b0000, 0, 2, 0, 0, 0, 1, 0);
    // r0 destination and r0 source
    tv[15].s = mk_s(1, 6'h00, 6'h20, 1, 2, 0, 1, 2, 0);
    tv[15].e = mk_e(1, 1, 1, 2, 4'b0000, 0, 0, 0, 0, 0, 0, 2);
    tv[16].s = mk_s(1, 6'h08, 6'h00, 0, 9, 9, 32'h1234, 0, 16'h8000);
    tv[16].e = mk_e(1, 1, 0, 32'hFFFF8000, 4'b0000, 1, 9, 0, 0, 0, 0, 0);
    tv[17].s = mk_s(1, 6'h0E, 6'h00, 1, 10, 10, 32'hF, 0, 16'h8000);
    tv[17].e = mk_e(1, 1, 32'hF, 32'h00008000, 4'b0110, 1, 10, 0, 0, 0, 0, 0);
    tv[18].s = mk_s(1, 6'h00, 6'h27, 10, 3, 11, 0, 3, 0);
    tv[18].s.ex_res = 32'h5A;
    tv[18].e = mk_e(1, 1, 32'h5A, 3, 4'b0111, 1, 11, 0, 0, 0, 0, 3);
    tv[19].s = mk_s(1, 6'h00, 6'h2A, 1, 2, 12, 1, 2, 0);
    tv[19].e = mk_e(1, 1, 1, 2, 4'b1010, 1, 12, 0, 0, 0, 0, 2);
    tv[20].s = mk_s(1, 6'h00, 6'h23, 1, 2, 13, 8, 3, 0);
    tv[20].e = mk_e(1, 1, 8, 3, 4'b0010, 1, 13, 0, 0, 0, 0, 3);
    // three stalled cycles, then flush during stall, then idle
    tv[21].s = mk_s(1, 6'h00, 6'h20, 1, 2, 14, 32'h11, 32'h22, 0);
    tv[21].s.stall = 1;
    tv[21].e = mk_e(0, 1, 8, 3, 4'b0010, 1, 13, 0, 0, 0, 0, 3);
    tv[22]   = tv[21];
    tv[23]   = tv[21];
    tv[24]   = tv[21];
    tv[24].s.fl = 1;
    tv[24].e = mk_e(0, 0, 8, 3, 4'b0010, 0, 13, 0, 0, 0, 0, 3);
    tv[25].s = mk_s(0, 6'h00, 6'h00, 0, 0, 0, 0, 0, 0);
    tv[25].e = mk_e(1, 0, 8, 3, 4'b0010, 0, 13, 0, 0, 0, 0, 3);
    // ori, then plain flush drops the incoming instruction
    tv[26].s = mk_s(1, 6'h0D, 6'h00, 1, 15, 15, 32'hF0, 0, 16'h000F);
    tv[26].e = mk_e(1, 1, 32'hF0, 32'hF, 4'b0101, 1, 15, 0, 0, 0, 0, 0);
    tv[27].s = mk_s(1, 6'h00, 6'h20, 1, 2, 14, 1, 2, 0);
    tv[27].s.fl = 1;
    tv[27].e = mk_e(0, 0, 32'hF0, 32'hF, 4'b0101, 0, 15, 0, 0, 0, 0, 0);
    // held load: rt as I-type destination is not a hazard and gets no EX value
    tv[28].s = mk_s(1, 6'h23, 6'h00, 1, 6, 6, 32'h100, 0, 16'h0004);
    tv[28].e = mk_e(1, 1, 32'h100, 4, 4'b0000, 1, 6, 1, 0, 0, 0, 0);
    tv[29].s = mk_s(1, 6'h08, 6'h00, 1, 6, 6, 2, 0, 16'h0001);
    tv[29].s.ex_res = 32'h999;
    tv[29].e = mk_e(1, 1, 2, 1, 4'b0000, 1, 6, 0, 0, 0, 0, 0);
    // sw whose store data (rt) comes from a held load stalls
    tv[30]   = tv[28];
    tv[31].s = mk_s(1, 6'h2B, 6'h00, 1, 6, 6, 32'h300, 0, 16'h0008);
    tv[31].e = mk_e(0, 0, 32'h100, 4, 4'b0000, 0, 6, 0, 0, 0, 0, 0);

    s = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(s);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    #1;
    check_outputs(-1, mk_e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) begin
      drive(tv[i].s);
      sb_q.push_back(tv[i].e);
      #1;
      chk("in_ready", i, 32'(in_ready), 32'(tv[i].e.rdy));
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard vec %0d: queue empty", i);
      end else begin
        e = sb_q.pop_front();
        check_outputs(i, e);
      end
    end

    // Asynchronous reset mid-stream, then acceptance on the first edge after release
    drive(mk_s(1, 6'h00, 6'h20, 1, 2, 3, 5, 7, 0));
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 100, 32'(out_valid), 32'd1);
    chk("pre_rst_alu_a", 100, alu_a, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid",  101, 32'(out_valid),  32'd0);
    chk("rst_alu_a",  101, alu_a,           32'd0);
    chk("rst_alu_b",  101, alu_b,           32'd0);
    chk("rst_wr_en",  101, 32'(out_wr_en),  32'd0);
    chk("rst_wr_idx", 101, 32'(out_wr_idx), 32'd0);
    drive(mk_s(1, 6'h00, 6'h20, 1, 2, 9, 32'h21, 32'h22, 0));
    @(posedge clk);
    #1;
    chk("in_rst_valid", 102, 32'(out_valid), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid",  103, 32'(out_valid),  32'd1);
    chk("post_rst_alu_a",  103, alu_a,           32'h21);
    chk("post_rst_alu_b",  103, alu_b,           32'h22);
    chk("post_rst_wr_idx", 103, 32'(out_wr_idx), 32'd9);
    drive(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
